// File: rtl/sram_fifo_if.sv
// Stream and SRAM-driver command signals of sram_fifo.
// The master view belongs to the FIFO and the slave view to its surroundings.
interface sram_fifo_if #(
   parameter int unsigned DEPTH_LOG2 = 17
);
   logic [7:0]            wr_data;
   logic                  wr_valid;
   logic                  wr_ready;
   logic [7:0]            rd_data;
   logic                  rd_valid;
   logic                  rd_ready;
   logic [DEPTH_LOG2+1:0] level;
   logic                  mem_wr_en;
   logic                  mem_rd_en;
   logic [23:0]           mem_address;
   logic [7:0]            mem_data_out;
   logic [7:0]            mem_data_in;
   logic                  mem_completed;

   modport master (
      input  wr_data, wr_valid, rd_ready, mem_data_in, mem_completed,
      output wr_ready, rd_data, rd_valid, level, mem_wr_en, mem_rd_en, mem_address, mem_data_out
   );

   modport slave (
      output wr_data, wr_valid, rd_ready, mem_data_in, mem_completed,
      input  wr_ready, rd_data, rd_valid, level, mem_wr_en, mem_rd_en, mem_address, mem_data_out
   );
endinterface

// File: rtl/sram_fifo.sv
// Byte-wide valid/ready FIFO whose storage is an external serial SRAM reached through a
// single-byte command driver, with one holding register on each side of the memory.
module sram_fifo #(
   parameter int unsigned DEPTH_LOG2  = 17,
   parameter logic [23:0] BASE_ADDR   = 24'h000000,
   parameter int unsigned RESET_QUIET = 256
) (
   input logic         clk,
   input logic         rst,
   sram_fifo_if.master bus
);

   localparam logic [2:0] QUIET    = 3'd0;
   localparam logic [2:0] IDLE     = 3'd1;
   localparam logic [2:0] WR_REQ   = 3'd2;
   localparam logic [2:0] WR_WAIT  = 3'd3;
   localparam logic [2:0] RD_REQ   = 3'd4;
   localparam logic [2:0] RD_WAIT1 = 3'd5;
   localparam logic [2:0] RD_WAIT2 = 3'd6;

   localparam int unsigned QW = (RESET_QUIET > 1) ? $clog2(RESET_QUIET) : 1;
   localparam int unsigned LW = DEPTH_LOG2 + 2;
   localparam logic [QW-1:0] QUIET_LAST = QW'(RESET_QUIET - 1);
   localparam logic [DEPTH_LOG2:0] FULL = {1'b1, {DEPTH_LOG2{1'b0}}};

   logic [2:0]            state_q, state_d;
   logic [QW-1:0]         qcnt_q, qcnt_d;
   logic [DEPTH_LOG2-1:0] wptr_q, wptr_d;
   logic [DEPTH_LOG2-1:0] rptr_q, rptr_d;
   logic [DEPTH_LOG2:0]   count_q, count_d;
   logic                  in_valid_q, in_valid_d;
   logic [7:0]            in_data_q, in_data_d;
   logic                  out_valid_q, out_valid_d;
   logic [7:0]            out_data_q, out_data_d;
   logic                  last_rd_q, last_rd_d;
   logic [23:0]           addr_q, addr_d;
   logic [7:0]            wdata_q, wdata_d;

   logic wr_ready;
   logic wr_accept;
   logic rd_take;
   logic wr_elig;
   logic rd_elig;

   assign wr_ready  = !in_valid_q && (state_q != QUIET);
   assign wr_accept = bus.wr_valid && wr_ready;
   assign rd_take   = out_valid_q && bus.rd_ready;
   assign wr_elig   = in_valid_q && (count_q < FULL);
   assign rd_elig   = !out_valid_q && (count_q != '0);

   assign bus.wr_ready     = wr_ready;
   assign bus.rd_valid     = out_valid_q;
   assign bus.rd_data      = out_data_q;
   assign bus.level        = LW'(count_q) + LW'(in_valid_q) + LW'(out_valid_q);
   assign bus.mem_wr_en    = (state_q == WR_REQ);
   assign bus.mem_rd_en    = (state_q == RD_REQ);
   assign bus.mem_address  = addr_q;
   assign bus.mem_data_out = wdata_q;

   always_comb begin
      state_d     = state_q;
      qcnt_d      = qcnt_q;
      wptr_d      = wptr_q;
      rptr_d      = rptr_q;
      count_d     = count_q;
      in_valid_d  = in_valid_q;
      in_data_d   = in_data_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      last_rd_d   = last_rd_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;

      if (wr_accept) begin
         in_valid_d = 1'b1;
         in_data_d  = bus.wr_data;
      end
      if (rd_take) begin
         out_valid_d = 1'b0;
      end

      unique case (state_q)
         QUIET: begin
            if (qcnt_q == QUIET_LAST) begin
               state_d = IDLE;
            end else begin
               qcnt_d = qcnt_q + QW'(1);
            end
         end
         IDLE: begin
            // On contention, alternate starting from whichever side was not granted last.
            if (wr_elig && (!rd_elig || last_rd_q)) begin
               state_d   = WR_REQ;
               last_rd_d = 1'b0;
               addr_d    = BASE_ADDR + 24'(wptr_q);
               wdata_d   = in_data_q;
            end else if (rd_elig) begin
               state_d   = RD_REQ;
               last_rd_d = 1'b1;
               addr_d    = BASE_ADDR + 24'(rptr_q);
            end
         end
         WR_REQ: state_d = WR_WAIT;
         WR_WAIT: begin
            if (bus.mem_completed) begin
               wptr_d     = wptr_q + DEPTH_LOG2'(1);
               count_d    = count_q + (DEPTH_LOG2 + 1)'(1);
               in_valid_d = 1'b0;
               state_d    = IDLE;
            end
         end
         RD_REQ: state_d = RD_WAIT1;
         RD_WAIT1: begin
            if (bus.mem_completed) begin
               out_data_d  = bus.mem_data_in;
               out_valid_d = 1'b1;
               rptr_d      = rptr_q + DEPTH_LOG2'(1);
               count_d     = count_q - (DEPTH_LOG2 + 1)'(1);
               state_d     = RD_WAIT2;
            end
         end
         // The driver's second read pulse marks the SPI bus as released.
         RD_WAIT2: begin
            if (bus.mem_completed) begin
               state_d = IDLE;
            end
         end
         default: state_d = QUIET;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= QUIET;
         qcnt_q      <= '0;
         wptr_q      <= '0;
         rptr_q      <= '0;
         count_q     <= '0;
         in_valid_q  <= 1'b0;
         in_data_q   <= 8'h00;
         out_valid_q <= 1'b0;
         out_data_q  <= 8'h00;
         last_rd_q   <= 1'b0;
         addr_q      <= BASE_ADDR;
         wdata_q     <= 8'h00;
      end else begin
         state_q     <= state_d;
         qcnt_q      <= qcnt_d;
         wptr_q      <= wptr_d;
         rptr_q      <= rptr_d;
         count_q     <= count_d;
         in_valid_q  <= in_valid_d;
         in_data_q   <= in_data_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         last_rd_q   <= last_rd_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
      end
   end

endmodule
